// File: rtl/rr_collector_pkg.sv
// rr_collector_pkg: shared helpers for the round-robin result collector.
//   idx_width(n) - width of a lane index, never narrower than one bit.
//   lane_idx_t   - generous lane-index container for code that handles indices
//                  before they are sliced down to idx_width(NUM_LANES).
package rr_collector_pkg;

    localparam int LANE_IDX_MAX_W = 16;

    typedef logic [LANE_IDX_MAX_W-1:0] lane_idx_t;

    // A single-lane collector still carries a 1-bit (constant 0) index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_collector_out_reg.sv
// Purpose: one-entry valid/ready output register holding a result word plus its source lane.
// Latency: one cycle from load to out_valid; the payload is registered only, with no bypass.
// Backpressure: load_ok drops while a word is held and out_ready is low; the payload stays stable.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   in_vld        load strobe (the caller only asserts it while load_ok is high)
//   in_dat/in_idx payload to load
//   load_ok       register is empty or is being drained this cycle
//   out_data, out_lane_idx, out_valid, out_ready   downstream valid/ready stream
module rr_collector_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_dat,
    input  logic [IDX_W-1:0]      in_idx,
    output logic                  load_ok,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_lane_idx,
    output logic                  out_valid,
    input  logic                  out_ready
);

    assign load_ok = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_lane_idx <= '0;
        end else if (in_vld) begin
            // Covers the simultaneous drain-and-refill case: valid stays high.
            out_valid    <= 1'b1;
            out_data     <= in_dat;
            out_lane_idx <= in_idx;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/rr_collector.sv
// Purpose: in-order gatherer of results from NUM_LANES lanes that were issued work round-robin.
// Latency: one cycle from lane accept to out_valid; one word per cycle at full throughput.
// Backpressure: only the expected lane sees ready, and only while the output register can load.
//
// Optional feature: define RR_COLLECTOR_TIMEOUT_EN to enable the stall watchdog (timeout_err).
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   lane_data       lane i result at [i*DATA_WIDTH +: DATA_WIDTH]
//   lane_valid      per-lane result valid
//   lane_ready      per-lane accept; only the expected lane can be ready
//   out_data        merged result, issue order
//   out_lane_idx    source lane of out_data
//   out_valid       out_data holds a result
//   out_ready       downstream accepts
//   expect_one_hot  one-hot pointer to the lane whose turn it is
//   timeout_err     sticky stall error (constant 0 without the watchdog)
module rr_collector
    import rr_collector_pkg::*;
#(
    parameter int  NUM_LANES      = 2,
    parameter int  DATA_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int IDX_W          = idx_width(NUM_LANES)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
    input  logic [NUM_LANES-1:0]            lane_valid,
    output logic [NUM_LANES-1:0]            lane_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [IDX_W-1:0]                out_lane_idx,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES-1:0]            expect_one_hot,
    output logic                            timeout_err
);

    logic [NUM_LANES-1:0]  expect_q;
    logic                  load_ok;
    logic                  xfer_vld;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic [IDX_W-1:0]      sel_idx;

    // rst_n gates ready so a lane never believes a word was taken during reset.
    assign lane_ready = expect_q & {NUM_LANES{load_ok & rst_n}};
    assign xfer_vld   = |(lane_valid & lane_ready);

    // One-hot AND-OR mux and one-hot to index encode; the pointer is
    // always exactly one-hot, so no priority is needed.
    always_comb begin
        sel_dat = '0;
        sel_idx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sel_dat = sel_dat | (lane_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{expect_q[i]}});
            if (expect_q[i]) begin
                sel_idx = sel_idx | IDX_W'(i);
            end
        end
    end

    // Turn pointer: rotate left on every accepted word, holding otherwise.
    if (NUM_LANES == 1) begin : g_single
        assign expect_q = 1'b1;
    end else begin : g_multi
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                expect_q <= NUM_LANES'(1);
            end else if (xfer_vld) begin
                expect_q <= {expect_q[NUM_LANES-2:0], expect_q[NUM_LANES-1]};
            end
        end
    end

    assign expect_one_hot = expect_q;

    rr_collector_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vld       (xfer_vld),
        .in_dat       (sel_dat),
        .in_idx       (sel_idx),
        .load_ok      (load_ok),
        .out_data     (out_data),
        .out_lane_idx (out_lane_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

`ifdef RR_COLLECTOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             stall;
    logic             timeout_q;

    // A stall is only charged while we could take a word but the expected
    // lane has nothing; downstream backpressure is not the lane's fault.
    assign stall = load_ok & ~|(lane_valid & expect_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (xfer_vld) begin
                stall_cnt <= '0;
            end else if (stall && (stall_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
                // Saturates at the limit so the counter never wraps.
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (stall_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
